// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, instruction-length
// prefix and the opcodes the control decoder also relies on.
package fetch_sequencer_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH_LO = 3'd1;
    localparam logic [2:0] ST_FETCH_HI = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_MEM      = 3'd4;
    localparam logic [2:0] ST_SYS      = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        FETCH_LO = ST_FETCH_LO,
        FETCH_HI = ST_FETCH_HI,
        EXEC     = ST_EXEC,
        MEM      = ST_MEM,
        SYS      = ST_SYS
    } state_t;

    localparam logic [1:0] TWO_BYTE_PREFIX = 2'b11;

    localparam logic [4:0] OP_SW = 5'b11100;
    localparam logic [4:0] OP_LW = 5'b11110;
    localparam logic [4:0] OP_JR = 5'b11010;

    // A first byte carrying the prefix in its top two bits needs a second byte.
    function automatic logic isTwoByte(input logic [7:0] lo);
        return lo[7:6] == TWO_BYTE_PREFIX;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of memory-port, decoder and datapath signals around the fetch sequencer.
// The master modport is the sequencer side; slave is the surrounding system.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 8
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;
    logic              MemRead;
    logic              MemWrite;
    logic              Syscalls;
    logic [ADDR_W-1:0] data_addr;
    logic [7:0]        data_wdata;
    logic [15:0]       instr;
    logic              instr_valid;
    logic [1:0]        pc_step;
    logic [7:0]        data_rdata;
    logic              pc_en;
    logic              sys_req;
    logic              sys_ack;
    logic [15:0]       instr_count;

    modport master (
        input  pc, mem_rdata, mem_ready, MemRead, MemWrite, Syscalls,
               data_addr, data_wdata, sys_ack,
        output mem_addr, mem_rd, mem_wr, mem_wdata, instr, instr_valid,
               pc_step, data_rdata, pc_en, sys_req, instr_count
    );

    modport slave (
        output pc, mem_rdata, mem_ready, MemRead, MemWrite, Syscalls,
               data_addr, data_wdata, sys_ack,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, instr, instr_valid,
               pc_step, data_rdata, pc_en, sys_req, instr_count
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer sharing one byte-wide memory port between
// instruction fetch and lw/sw data accesses, with one commit pulse per instruction.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    state_t            r_state;
    logic [7:0]        r_lo;
    logic [15:0]       r_instr;
    logic [1:0]        r_pcStep;
    logic [7:0]        r_dataRdata;
    logic [ADDR_W-1:0] r_dataAddr;
    logic [7:0]        r_dataWdata;
    logic              r_isStore;
    logic [15:0]       r_instrCount;

    logic              w_pcEn;
    logic [ADDR_W-1:0] w_memAddr;

    // Commit only when the instruction's last step completes; mem_ready and
    // sys_ack are ignored in every other state.
    always_comb begin
        w_pcEn = 1'b0;
        case (r_state)
            EXEC:    w_pcEn = !bus.MemWrite && !bus.MemRead && !bus.Syscalls;
            MEM:     w_pcEn = bus.mem_ready;
            SYS:     w_pcEn = bus.sys_ack;
            default: w_pcEn = 1'b0;
        endcase
    end

    // Fetch addresses follow pc live so a PC update at commit is seen at once.
    always_comb begin
        w_memAddr = r_dataAddr;
        case (r_state)
            FETCH_LO: w_memAddr = bus.pc;
            FETCH_HI: w_memAddr = bus.pc + ADDR_W'(1);
            default:  w_memAddr = r_dataAddr;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lo         <= 8'h00;
            r_instr      <= 16'h0000;
            r_pcStep     <= 2'd1;
            r_dataRdata  <= 8'h00;
            r_dataAddr   <= '0;
            r_dataWdata  <= 8'h00;
            r_isStore    <= 1'b0;
            r_instrCount <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: r_state <= FETCH_LO;
                FETCH_LO: begin
                    if (bus.mem_ready) begin
                        r_lo <= bus.mem_rdata;
                        if (isTwoByte(bus.mem_rdata)) begin
                            r_state <= FETCH_HI;
                        end else begin
                            r_instr  <= {8'h00, bus.mem_rdata};
                            r_pcStep <= 2'd1;
                            r_state  <= EXEC;
                        end
                    end
                end
                FETCH_HI: begin
                    if (bus.mem_ready) begin
                        r_instr  <= {bus.mem_rdata, r_lo};
                        r_pcStep <= 2'd2;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (bus.MemWrite || bus.MemRead) begin
                        r_dataAddr  <= bus.data_addr;
                        r_dataWdata <= bus.data_wdata;
                        r_isStore   <= bus.MemWrite;
                        r_state     <= MEM;
                    end else if (bus.Syscalls) begin
                        r_state <= SYS;
                    end else begin
                        r_state <= FETCH_LO;
                    end
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        if (!r_isStore) begin
                            r_dataRdata <= bus.mem_rdata;
                        end
                        r_state <= FETCH_LO;
                    end
                end
                SYS: begin
                    if (bus.sys_ack) begin
                        r_state <= FETCH_LO;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_pcEn) begin
                r_instrCount <= r_instrCount + 16'd1;
            end
        end
    end

    assign bus.mem_addr    = w_memAddr;
    assign bus.mem_rd      = (r_state == FETCH_LO) || (r_state == FETCH_HI) ||
                             ((r_state == MEM) && !r_isStore);
    assign bus.mem_wr      = (r_state == MEM) && r_isStore;
    assign bus.mem_wdata   = r_dataWdata;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = (r_state == EXEC);
    assign bus.pc_step     = r_pcStep;
    assign bus.data_rdata  = r_dataRdata;
    assign bus.pc_en       = w_pcEn;
    assign bus.sys_req     = (r_state == SYS);
    assign bus.instr_count = r_instrCount;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// instructions compared against a per-instruction behavioural model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(8)) bus();

    fetch_sequencer #(.ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [7:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr];

    int checks   = 0;
    int failures = 0;

    int          mCount;
    logic [7:0]  mDataRdata;
    logic [7:0]  expRd[$];
    logic [7:0]  expWr[$];
    logic [15:0] expInstr;
    logic [1:0]  expStep;
    int          expCycles;

    int          rCycles, rValid, rSys;
    bit          rPcEn, rPcEnAfter, rTimeout;
    logic [15:0] rInstr, rCountAfter;
    logic [1:0]  rStep;
    logic [7:0]  rdq[$];
    logic [7:0]  wrq[$];
    logic [7:0]  wdq[$];

    // Instruction-level model: length from the first byte, a fixed cycle
    // cost per phase, and the list of addresses each access should present.
    task automatic model_instr(input logic [7:0] pcv, input bit rd, input bit wr,
                               input bit sys, input logic [7:0] daddr,
                               input int fW, input int dW, input int aW);
        logic [7:0] lo, hi, pc1;
        bit two;
        pc1 = pcv + 8'd1;
        lo  = mem[pcv];
        hi  = mem[pc1];
        two = (lo >= 8'hC0);
        expInstr = two ? {hi, lo} : {8'h00, lo};
        expStep  = two ? 2'd2 : 2'd1;
        expRd.delete();
        expWr.delete();
        for (int k = 0; k <= fW; k++) expRd.push_back(pcv);
        if (two) for (int k = 0; k <= fW; k++) expRd.push_back(pc1);
        expCycles = (two ? 2 : 1) * (fW + 1) + 1;
        if (wr) begin
            for (int k = 0; k <= dW; k++) expWr.push_back(daddr);
            expCycles += dW + 1;
        end else if (rd) begin
            for (int k = 0; k <= dW; k++) expRd.push_back(daddr);
            mDataRdata = mem[daddr];
            expCycles += dW + 1;
        end else if (sys) begin
            expCycles += aW + 1;
        end
        mCount = (mCount + 1) % 65536;
    endtask

    // Plays memory, decoder and syscall handler for one instruction starting in
    // FETCH_LO, recording what the DUT presents each cycle until its commit.
    task automatic run_instr(input logic [7:0] pcv, input bit rd, input bit wr,
                             input bit sys, input logic [7:0] daddr,
                             input logic [7:0] wdata, input int fW, input int dW,
                             input int aW, input bit ackNoise);
        int  waitLeft = 0;
        int  sysCnt   = 0;
        bit  inProg   = 0;
        bit  validSeen = 0;
        rCycles = 0; rValid = 0; rSys = 0; rPcEn = 0; rPcEnAfter = 0; rTimeout = 0;
        rdq.delete(); wrq.delete(); wdq.delete();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.pc         = pcv;
                bus.MemRead    = rd;
                bus.MemWrite   = wr;
                bus.Syscalls   = sys;
                bus.data_addr  = daddr;
                bus.data_wdata = wdata;
            end else if (validSeen) begin
                bus.data_addr  = ~daddr;
                bus.data_wdata = ~wdata;
                bus.MemRead    = 1'($urandom_range(0, 1));
                bus.MemWrite   = 1'($urandom_range(0, 1));
                bus.Syscalls   = 1'($urandom_range(0, 1));
            end
            if (bus.mem_rd || bus.mem_wr) begin
                if (!inProg) begin
                    waitLeft = validSeen ? dW : fW;
                    inProg = 1;
                end
                if (waitLeft > 0) begin
                    bus.mem_ready = 1'b0;
                    waitLeft--;
                end else begin
                    bus.mem_ready = 1'b1;
                    inProg = 0;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            if (bus.sys_req) begin
                bus.sys_ack = (sysCnt == aW);
                sysCnt++;
            end else begin
                bus.sys_ack = ackNoise;
            end
            #1;
            rCycles++;
            if (bus.mem_rd) rdq.push_back(bus.mem_addr);
            if (bus.mem_wr) begin
                wrq.push_back(bus.mem_addr);
                wdq.push_back(bus.mem_wdata);
            end
            if (bus.instr_valid) begin
                rValid++;
                rInstr = bus.instr;
                rStep  = bus.pc_step;
                validSeen = 1;
            end
            if (bus.sys_req) rSys++;
            if (bus.pc_en) begin
                rPcEn = 1;
                break;
            end
        end
        if (!rPcEn) begin
            rTimeout = 1;
        end else begin
            @(posedge clk);
            #1;
            rCountAfter = bus.instr_count;
            rPcEnAfter  = bus.pc_en;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.pc = 8'h00; bus.mem_ready = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        bus.Syscalls = 1'b0; bus.data_addr = 8'h00; bus.data_wdata = 8'h00; bus.sys_ack = 1'b0;
        mCount = 0;
        mDataRdata = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.mem_rd, bus.mem_wr, bus.pc_en, bus.instr_valid, bus.sys_req} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_strobes got=%b want=00000",
                     {bus.mem_rd, bus.mem_wr, bus.pc_en, bus.instr_valid, bus.sys_req});
        end
        checks++;
        if (bus.instr !== 16'h0000) begin
            failures++; $display("[TB] FAIL reset_instr got=%h want=0000", bus.instr);
        end
        checks++;
        if (bus.pc_step !== 2'd1) begin
            failures++; $display("[TB] FAIL reset_pc_step got=%0d want=1", bus.pc_step);
        end
        checks++;
        if (bus.data_rdata !== 8'h00) begin
            failures++; $display("[TB] FAIL reset_data_rdata got=%h want=00", bus.data_rdata);
        end
        checks++;
        if (bus.instr_count !== 16'h0000) begin
            failures++; $display("[TB] FAIL reset_count got=%h want=0000", bus.instr_count);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_rd !== 1'b0) begin
            failures++; $display("[TB] FAIL idle_no_read got=%b want=0", bus.mem_rd);
        end
    endtask

    task automatic test_one_byte;
        mem[8'h10] = 8'h05;
        model_instr(8'h10, 0, 0, 0, 8'h00, 0, 0, 0);
        run_instr(8'h10, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        checks++;
        if (rInstr !== 16'h0005 || rStep !== 2'd1) begin
            failures++;
            $display("[TB] FAIL one_byte_instr got=%h/%0d want=0005/1", rInstr, rStep);
        end
        checks++;
        if (rCycles !== 2 || rTimeout) begin
            failures++; $display("[TB] FAIL one_byte_cycles got=%0d want=2", rCycles);
        end
        checks++;
        if (rdq.size() < 1 || rdq[0] !== 8'h10) begin
            failures++; $display("[TB] FAIL one_byte_first_addr got_reads=%0d want addr 10", rdq.size());
        end
        checks++;
        if (rCountAfter !== 16'(mCount) || rValid !== 1) begin
            failures++;
            $display("[TB] FAIL one_byte_count got=%0d valid=%0d want=%0d valid=1", rCountAfter, rValid, mCount);
        end
    endtask

    task automatic test_two_byte;
        mem[8'h20] = 8'hE9;
        mem[8'h21] = 8'h7F;
        model_instr(8'h20, 0, 0, 0, 8'h00, 0, 0, 0);
        run_instr(8'h20, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        checks++;
        if (rInstr !== 16'h7FE9 || rStep !== 2'd2) begin
            failures++;
            $display("[TB] FAIL two_byte_instr got=%h/%0d want=7fe9/2", rInstr, rStep);
        end
        checks++;
        if (rCycles !== 3 || rdq.size() !== 2 || rdq[1] !== 8'h21) begin
            failures++;
            $display("[TB] FAIL two_byte_fetch got cycles=%0d reads=%0d want cycles=3 reads=2 second=21",
                     rCycles, rdq.size());
        end
    endtask

    task automatic test_wrap;
        mem[8'hFF] = 8'hF0;
        mem[8'h00] = 8'h3C;
        model_instr(8'hFF, 0, 0, 0, 8'h00, 0, 0, 0);
        run_instr(8'hFF, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        checks++;
        if (rdq.size() !== 2 || rdq[1] !== 8'h00) begin
            failures++;
            $display("[TB] FAIL wrap_hi_addr got reads=%0d want reads=2 second=00", rdq.size());
        end
        checks++;
        if (rInstr !== 16'h3CF0) begin
            failures++; $display("[TB] FAIL wrap_instr got=%h want=3cf0", rInstr);
        end
    endtask

    task automatic test_load_wait;
        bit bad = 0;
        mem[8'h30] = 8'h01;
        mem[8'h40] = 8'hA5;
        model_instr(8'h30, 1, 0, 0, 8'h40, 0, 3, 0);
        run_instr(8'h30, 1, 0, 0, 8'h40, 8'h00, 0, 3, 0, 0);
        if (rdq.size() !== 5) bad = 1;
        else for (int k = 1; k < 5; k++) if (rdq[k] !== 8'h40) bad = 1;
        checks++;
        if (bad) begin
            failures++; $display("[TB] FAIL load_addr_hold got reads=%0d want 1 fetch + 4 at 40", rdq.size());
        end
        checks++;
        if (bus.data_rdata !== 8'hA5) begin
            failures++; $display("[TB] FAIL load_data got=%h want=a5", bus.data_rdata);
        end
        checks++;
        if (rCycles !== 6 || rPcEnAfter || rTimeout) begin
            failures++;
            $display("[TB] FAIL load_commit got cycles=%0d pc_en_after=%0b want cycles=6 pc_en_after=0",
                     rCycles, rPcEnAfter);
        end
    endtask

    task automatic test_store_priority;
        bit bad = 0;
        mem[8'h31] = 8'h02;
        model_instr(8'h31, 1, 1, 0, 8'h41, 0, 1, 0);
        run_instr(8'h31, 1, 1, 0, 8'h41, 8'h5A, 0, 1, 0, 0);
        if (wrq.size() !== 2) bad = 1;
        else for (int k = 0; k < 2; k++) if (wrq[k] !== 8'h41 || wdq[k] !== 8'h5A) bad = 1;
        checks++;
        if (bad) begin
            failures++; $display("[TB] FAIL store_write got writes=%0d want 2 at 41 data 5a", wrq.size());
        end
        checks++;
        if (rdq.size() !== 1) begin
            failures++; $display("[TB] FAIL store_no_read got reads=%0d want=1", rdq.size());
        end
        checks++;
        if (bus.data_rdata !== mDataRdata || rCycles !== expCycles) begin
            failures++;
            $display("[TB] FAIL store_hold got data=%h cycles=%0d want data=%h cycles=%0d",
                     bus.data_rdata, rCycles, mDataRdata, expCycles);
        end
    endtask

    task automatic test_syscall;
        mem[8'h32] = 8'h03;
        model_instr(8'h32, 0, 0, 1, 8'h00, 0, 0, 4);
        run_instr(8'h32, 0, 0, 1, 8'h00, 8'h00, 0, 0, 4, 1);
        checks++;
        if (rSys !== 5) begin
            failures++; $display("[TB] FAIL sys_req_len got=%0d want=5", rSys);
        end
        checks++;
        if (rCycles !== expCycles || rCountAfter !== 16'(mCount)) begin
            failures++;
            $display("[TB] FAIL sys_commit got cycles=%0d count=%0d want cycles=%0d count=%0d",
                     rCycles, rCountAfter, expCycles, mCount);
        end
    endtask

    task automatic test_reset_mid_store;
        bit seen = 0;
        mem[8'h50] = 8'h02;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.pc = 8'h50; bus.MemRead = 1'b0; bus.MemWrite = 1'b1; bus.Syscalls = 1'b0;
                bus.data_addr = 8'h60; bus.data_wdata = 8'h33; bus.sys_ack = 1'b0;
            end
            bus.mem_ready = bus.mem_wr ? 1'b0 : 1'b1;
            #1;
            if (bus.mem_wr) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++; $display("[TB] FAIL midstore_reach got no write want write within 20 cycles");
        end
        repeat (2) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
        end
        checks++;
        if (bus.instr_count !== 16'(mCount) || bus.pc_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midstore_stall got count=%0d pc_en=%b want count=%0d pc_en=0",
                     bus.instr_count, bus.pc_en, mCount);
        end
        #2 reset = 1'b1;
        #1;
        mCount = 0;
        mDataRdata = 8'h00;
        checks++;
        if ({bus.mem_wr, bus.mem_rd, bus.pc_en} !== 3'b000 || bus.instr_count !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL midstore_reset got wr/rd/pc_en=%b count=%0d want 000 count=0",
                     {bus.mem_wr, bus.mem_rd, bus.pc_en}, bus.instr_count);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.MemWrite = 1'b0;
        #1;
        checks++;
        if (bus.mem_rd !== 1'b0) begin
            failures++; $display("[TB] FAIL restart_idle got mem_rd=%b want=0", bus.mem_rd);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h50) begin
            failures++;
            $display("[TB] FAIL restart_fetch got rd=%b addr=%h want rd=1 addr=50", bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_random(input int n);
        logic [7:0] pcv, daddr, wdata;
        bit rd, wr, sys, noise, bad;
        int kind, fW, dW, aW;
        for (int i = 0; i < n; i++) begin
            pcv   = 8'($urandom);
            mem[pcv] = 8'($urandom);
            mem[8'(pcv + 8'd1)] = 8'($urandom);
            daddr = 8'($urandom);
            wdata = 8'($urandom);
            kind  = $urandom_range(0, 4);
            rd    = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
            wr    = (kind == 3);
            sys   = (kind == 4) || (kind >= 2 && $urandom_range(0, 1) == 1);
            fW    = $urandom_range(0, 2);
            dW    = $urandom_range(0, 2);
            aW    = $urandom_range(0, 3);
            noise = 1'($urandom_range(0, 1));
            model_instr(pcv, rd, wr, sys, daddr, fW, dW, aW);
            run_instr(pcv, rd, wr, sys, daddr, wdata, fW, dW, aW, noise);
            checks++;
            if (rTimeout) begin
                failures++; $display("[TB] FAIL rand%0d_timeout got no pc_en want pc_en within 200", i);
            end
            checks++;
            if (rInstr !== expInstr || rStep !== expStep) begin
                failures++;
                $display("[TB] FAIL rand%0d_instr got=%h/%0d want=%h/%0d", i, rInstr, rStep, expInstr, expStep);
            end
            checks++;
            if (rCycles !== expCycles) begin
                failures++; $display("[TB] FAIL rand%0d_cycles got=%0d want=%0d", i, rCycles, expCycles);
            end
            bad = (rdq.size() !== expRd.size());
            if (!bad) foreach (rdq[k]) if (rdq[k] !== expRd[k]) bad = 1;
            checks++;
            if (bad) begin
                failures++; $display("[TB] FAIL rand%0d_reads got=%0d want=%0d entries or addr differs",
                                     i, rdq.size(), expRd.size());
            end
            bad = (wrq.size() !== expWr.size());
            if (!bad) foreach (wrq[k]) if (wrq[k] !== expWr[k] || wdq[k] !== wdata) bad = 1;
            checks++;
            if (bad) begin
                failures++; $display("[TB] FAIL rand%0d_writes got=%0d want=%0d entries or addr/data differs",
                                     i, wrq.size(), expWr.size());
            end
            checks++;
            if (bus.data_rdata !== mDataRdata) begin
                failures++; $display("[TB] FAIL rand%0d_data got=%h want=%h", i, bus.data_rdata, mDataRdata);
            end
            checks++;
            if (rCountAfter !== 16'(mCount) || rPcEnAfter || rValid !== 1) begin
                failures++;
                $display("[TB] FAIL rand%0d_commit got count=%0d pc_en_after=%0b valid=%0d want count=%0d 0 1",
                         i, rCountAfter, rPcEnAfter, rValid, mCount);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        test_reset();
        test_one_byte();
        test_two_byte();
        test_wrap();
        test_load_wait();
        test_store_priority();
        test_syscall();
        test_reset_mid_store();
        test_random(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle sequencer between the 8-bit computer's single byte-wide memory port and the combinational `control` decoder.
- Fetches one or two instruction bytes at `pc` and assembles the 16-bit `instr`.
- Holds `instr` stable while the decoder resolves it.
- Performs the `lw`/`sw` data access on the same memory port.
- Stalls for syscalls.
- Issues a single commit pulse per instruction that gates PC update and register/accumulator writes.

## Interface
Parameters:
- `ADDR_W`, 8: memory and PC address width. Address arithmetic wraps modulo 2^ADDR_W.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  ADDR_W  current PC from the datapath.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_rd`  out  1  memory read request.
- `mem_wr`  out  1  memory write request.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data, valid when `mem_ready`=1.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `MemRead`  in  1  decoder: lw.
- `MemWrite`  in  1  decoder: sw.
- `Syscalls`  in  1  decoder: syscall.
- `data_addr`  in  ADDR_W  ALU-computed data address.
- `data_wdata`  in  8  store data.
- `instr`  out  16  assembled instruction, to decoder.
- `instr_valid`  out  1  high in EXEC.
- `pc_step`  out  2  instruction length: 1 or 2.
- `data_rdata`  out  8  captured load data.
- `pc_en`  out  1  one-cycle commit pulse.
- `sys_req`  out  1  syscall pending.
- `sys_ack`  in  1  syscall service complete.
- `instr_count`  out  16  committed instruction count; wraps 0xFFFF→0x0000.

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, EXEC, MEM, SYS.
- Reset forces IDLE immediately (asynchronous). Reset values:
  - All request and strobe outputs 0.
  - `instr`=0x0000, `data_rdata`=0x00, `pc_step`=1, `instr_count`=0.
- IDLE → FETCH_LO on the next edge, unconditionally.
- FETCH_LO:
  - Drives `mem_rd`=1, `mem_addr`=`pc`.
  - On `mem_ready`, captures `lo`=`mem_rdata`.
  - If `lo[7:6]`==2'b11, goes to FETCH_HI.
  - Otherwise loads `instr`={8'h00,lo}, `pc_step`=1, and goes to EXEC.
- FETCH_HI:
  - Drives `mem_rd`=1, `mem_addr`=`pc`+1 (wraps: 0xFF→0x00).
  - On `mem_ready`, loads `instr`={mem_rdata,lo}, `pc_step`=2, and goes to EXEC.
- EXEC: `instr_valid`=1 for exactly one cycle. The decoder outputs are sampled in this cycle:
  - MemWrite → MEM (store).
  - Else MemRead → MEM (load).
  - Else Syscalls → SYS.
  - Else `pc_en`=1 and go to FETCH_LO.
- MemRead and MemWrite both high: MemWrite wins.
- MEM:
  - The data address, write data and access direction are latched at EXEC exit.
  - Drives `mem_wr`/`mem_rd` with the latched `data_addr`/`data_wdata`.
  - On `mem_ready`: a load captures `data_rdata`; then `pc_en`=1 and go to FETCH_LO.
- SYS: `sys_req`=1. On `sys_ack`, `pc_en`=1 and go to FETCH_LO. `sys_ack` outside SYS is ignored.
- `instr_count` increments on every `pc_en`.
- `instr` and `data_rdata` hold their values until the next capture.

## Timing
- `mem_ready` is sampled at the rising edge while a request is asserted.
- Address, data and request are stable every cycle until that edge.
- Outputs are Moore-decoded from the state plus registered data; there is no combinational path from `mem_ready` to `mem_rd`/`mem_wr`.
- Cycles per instruction with zero-wait memory (`mem_ready` tied 1):
  - 1-byte ALU op: 2 (FETCH_LO, EXEC).
  - 2-byte ALU op: 3.
  - lw/sw: one more than the non-memory case.
  - Syscall: 3 + ack wait.
- Each wait cycle on `mem_ready` adds one cycle in the current state.
- `pc_en` is never high in two consecutive cycles. There is exactly one `pc_en` per instruction.
- Reset mid-access drops `mem_rd`/`mem_wr` in the same cycle. No partial commit: `pc_en` stays 0 and `instr_count` is unchanged.
- After reset deassert, the first `mem_rd` appears in the second cycle (IDLE, then FETCH_LO).

## Structure
- The shared package holds:
  - State encoding (3-bit localparams).
  - `TWO_BYTE_PREFIX`=2'b11.
  - Opcode constants shared with `control`: `OP_SW`=5'b11100, `OP_LW`=5'b11110, `OP_JR`=5'b11010.
- Single module; no sub-module is warranted. The FSM, the capture registers and the counter are all small.

## Test plan
- Tie `mem_ready`=1, set `pc`=0x10, place byte 0x05 at 0x10: `instr`=0x0005 and `pc_step`=1 in cycle 2 after IDLE; `pc_en` pulses once; `instr_count`=1.
- Place 0xE9 at 0x20 and 0x7F at 0x21, `pc`=0x20: second read at address 0x21, then `instr`=0x7FE9, `pc_step`=2, 3 cycles to `pc_en`.
- Set `pc`=0xFF, place byte 0xF0 at 0xFF: FETCH_HI drives `mem_addr`=0x00.
- lw (`MemRead`=1, `data_addr`=0x40) with `mem_ready` held low 3 cycles and data 0xA5: `mem_addr`=0x40 held 4 cycles, `data_rdata`=0xA5, single `pc_en`. Repeat with MemRead=MemWrite=1: write issued, no read.
- Syscall with `sys_ack` asserted 5 cycles after `sys_req`: `sys_req` high 5 cycles, then one `pc_en`; a `sys_ack` pulse during FETCH_LO has no effect.
- Assert `reset` during MEM of a sw with `mem_ready`=0: `mem_wr` drops immediately, `instr_count` unchanged, and a fetch from `pc` restarts 2 cycles after deassert.
